// File: rtl/wb_regfile.sv
// Write-back register file: 32 x 32 GPRs, $0 hardwired to zero,
// two bypassed combinational read ports and one registered debug port.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = rst && wb_wreg && (wb_wd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  // debug capture sees the array before this edge's write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_rdata <= '0;
    end else begin
      dbg_rdata <= regs[dbg_raddr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (wr_en && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst && re1 && (raddr1 != '0)) begin
      if (wr_en && (raddr1 == wb_wd)) begin
        rdata1 = wb_wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst && re2 && (raddr2 != '0)) begin
      if (wr_en && (raddr2 == wb_wd)) begin
        rdata2 = wb_wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, bypass,
// $0 hardwire, debug latency and write-counter saturation.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [15:0] wr_count;

  int tests;
  int fails;

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    wb_wd     = '0;
    wb_wreg   = 1'b0;
    wb_wdata  = '0;
    re1       = 1'b1;
    raddr1    = 5'd5;
    re2       = 1'b0;
    raddr2    = '0;
    dbg_raddr = '0;

    repeat (2) @(negedge clk);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_count", {16'h0, wr_count}, 32'h0);
    chk("rst_dbg", dbg_rdata, 32'h0);

    // write regs[5] then read it from array and debug port
    rst      = 1'b1;
    wb_wreg  = 1'b1;
    wb_wd    = 5'd5;
    wb_wdata = 32'h1234_5678;
    @(negedge clk);
    wb_wreg   = 1'b0;
    dbg_raddr = 5'd5;
    #1;
    chk("r5_array", rdata1, 32'h1234_5678);
    chk("r5_count", {16'h0, wr_count}, 32'h1);
    @(negedge clk);
    chk("r5_dbg", dbg_rdata, 32'h1234_5678);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("async_rdata1", rdata1, 32'h0);
    chk("async_count", {16'h0, wr_count}, 32'h0);
    chk("async_dbg", dbg_rdata, 32'h0);

    // write attempted while reset is held is lost
    wb_wreg  = 1'b1;
    wb_wd    = 5'd9;
    wb_wdata = 32'hCAFE_0009;
    @(negedge clk);
    rst     = 1'b1;
    wb_wreg = 1'b0;
    raddr1  = 5'd9;
    raddr2  = 5'd5;
    re2     = 1'b1;
    #1;
    chk("lost_r9", rdata1, 32'h0);
    chk("cleared_r5", rdata2, 32'h0);
    chk("lost_count", {16'h0, wr_count}, 32'h0);

    // write/read, port 2 disabled
    @(negedge clk);
    wb_wreg  = 1'b1;
    wb_wd    = 5'd3;
    wb_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_wreg = 1'b0;
    re1     = 1'b1;
    raddr1  = 5'd3;
    re2     = 1'b0;
    raddr2  = 5'd3;
    #1;
    chk("wr_rd_r3", rdata1, 32'hDEAD_BEEF);
    chk("re2_off", rdata2, 32'h0);
    chk("count_1", {16'h0, wr_count}, 32'h1);

    // bypass on both ports, debug captures old value
    @(negedge clk);
    wb_wreg   = 1'b1;
    wb_wd     = 5'd7;
    wb_wdata  = 32'hA5A5_0001;
    re1       = 1'b1;
    re2       = 1'b1;
    raddr1    = 5'd7;
    raddr2    = 5'd7;
    dbg_raddr = 5'd7;
    #1;
    chk("byp_p1", rdata1, 32'hA5A5_0001);
    chk("byp_p2", rdata2, 32'hA5A5_0001);
    re1 = 1'b0;
    #1;
    chk("byp_re1_off", rdata1, 32'h0);
    re1 = 1'b1;
    @(negedge clk);
    chk("byp_dbg_old", dbg_rdata, 32'h0);
    // write to 8 while port 1 reads 3 and port 2 bypasses 8
    wb_wd    = 5'd8;
    wb_wdata = 32'h0000_0011;
    raddr1   = 5'd3;
    raddr2   = 5'd8;
    #1;
    chk("other_addr", rdata1, 32'hDEAD_BEEF);
    chk("byp_r8", rdata2, 32'h0000_0011);
    @(negedge clk);
    wb_wreg = 1'b0;
    raddr1  = 5'd7;
    #1;
    chk("dbg_new", dbg_rdata, 32'hA5A5_0001);
    chk("r7_array", rdata1, 32'hA5A5_0001);
    chk("r8_array", rdata2, 32'h0000_0011);
    chk("count_3", {16'h0, wr_count}, 32'h3);

    // $0 hardwire
    @(negedge clk);
    wb_wreg   = 1'b1;
    wb_wd     = 5'd0;
    wb_wdata  = 32'hFFFF_FFFF;
    raddr1    = 5'd0;
    raddr2    = 5'd0;
    dbg_raddr = 5'd0;
    #1;
    chk("r0_byp_p1", rdata1, 32'h0);
    chk("r0_byp_p2", rdata2, 32'h0);
    @(negedge clk);
    wb_wreg = 1'b0;
    #1;
    chk("r0_after", rdata1, 32'h0);
    chk("r0_count", {16'h0, wr_count}, 32'h3);
    @(negedge clk);
    chk("r0_dbg", dbg_rdata, 32'h0);

    // debug latency: write at edge N, visible after N+1
    wb_wreg   = 1'b1;
    wb_wd     = 5'd31;
    wb_wdata  = 32'h0000_00FF;
    dbg_raddr = 5'd31;
    @(negedge clk);
    wb_wreg = 1'b0;
    chk("dbg_edge_n", dbg_rdata, 32'h0);
    @(negedge clk);
    chk("dbg_edge_n1", dbg_rdata, 32'h0000_00FF);
    chk("count_4", {16'h0, wr_count}, 32'h4);

    // counter saturation: 65531 more writes reach 65535
    wb_wreg  = 1'b1;
    wb_wd    = 5'd1;
    wb_wdata = 32'h0000_0100;
    repeat (65530) @(negedge clk);
    chk("count_fffe", {16'h0, wr_count}, 32'h0000_FFFE);
    @(negedge clk);
    chk("count_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
    repeat (3) @(negedge clk);
    chk("count_sat", {16'h0, wr_count}, 32'h0000_FFFF);
    wb_wreg = 1'b0;
    raddr1  = 5'd1;
    #1;
    chk("r1_value", rdata1, 32'h0000_0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the pipeline: consumes the write-back triple (wb_wd, wb_wreg, wb_wdata) produced by the MEM/WB pipeline register.
- Commits it to the 32 x 32-bit general register file.
- Serves the two decode-stage operand reads with same-cycle write-to-read bypass.
- Serves one registered debug read port for the bench and trace logic.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- wb_wd  input  ADDR_W  write-back destination register address
- wb_wreg  input  1  write-back enable (1 = write)
- wb_wdata  input  DATA_W  write-back data
- re1  input  1  read port 1 enable
- raddr1  input  ADDR_W  read port 1 address
- rdata1  output  DATA_W  read port 1 data, combinational
- re2  input  1  read port 2 enable
- raddr2  input  ADDR_W  read port 2 address
- rdata2  output  DATA_W  read port 2 data, combinational
- dbg_raddr  input  ADDR_W  debug read address
- dbg_rdata  output  DATA_W  debug read data, registered, 1-cycle latency
- wr_count  output  16  count of committed writes; saturates at 16'hFFFF

Behaviour:
- Reset:
  - rst=0 immediately, without waiting for a clock edge, clears all 32 registers, dbg_rdata and wr_count to 0.
  - While rst=0: rdata1=rdata2=0, and writes are ignored.
  - Reset asserted mid-write (same cycle as wb_wreg=1): the write is lost; the register reads 0 after release.
- Write:
  - On posedge clk with rst=1, wb_wreg=1 and wb_wd!=0: regs[wb_wd] <= wb_wdata, and wr_count increments by 1 unless already 16'hFFFF.
  - wb_wd=0 with wb_wreg=1: no write, no count.
- Read ports (combinational, each port independent; identical rules for port 2):
  - re1=0 -> rdata1=0.
  - raddr1=0 -> rdata1=0.
  - re1=1, raddr1==wb_wd, wb_wreg=1, wb_wd!=0 -> rdata1=wb_wdata (bypass: the value being written this cycle).
  - Otherwise rdata1=regs[raddr1].
- Simultaneous events:
  - Both read ports hitting the same bypassed address both return wb_wdata.
  - A read of a different address is unaffected by a concurrent write.
- Debug port:
  - On each posedge with rst=1: dbg_rdata <= value of regs[dbg_raddr] before this edge's write (no bypass). dbg_raddr=0 yields 0.
  - Write then read of the same register via the debug port needs 2 edges: the write edge, then the capture edge.
- Latency:
  - Written value is visible on rdata1/rdata2 in the same cycle via bypass, and from the array from the next cycle onward.
- No X propagation:
  - All outputs are defined whenever rst=1, including for unwritten registers (0 after reset).

Test Plan:
- Reset: drive rst=0 mid-simulation after writing regs[5]=32'h1234_5678 -> rdata1 with raddr1=5, re1=1 reads 0 during reset without a clock edge; wr_count=0, dbg_rdata=0.
- Write/read: write regs[3]=32'hDEAD_BEEF, next cycle re1=1 raddr1=3 -> rdata1=32'hDEAD_BEEF; re2=0 -> rdata2=0.
- Bypass: in one cycle wb_wreg=1, wb_wd=7, wb_wdata=32'hA5A5_0001, re1=re2=1, raddr1=raddr2=7 -> both read 32'hA5A5_0001 before the edge; a debug read of 7 in the same cycle captures the old value 0.
- $0 hardwire: wb_wreg=1, wb_wd=0, wb_wdata=32'hFFFF_FFFF -> raddr1=0 reads 0 in that cycle and after; wr_count unchanged.
- Counter saturation: force 65,535 committed writes, then 3 more -> wr_count stays 16'hFFFF.
- Debug latency: write regs[31]=32'h0000_00FF at edge N with dbg_raddr=31 -> dbg_rdata=0 after edge N, 32'h0000_00FF after edge N+1.
